// File: rtl/display_scanner.sv
// Four-digit multiplexed driver for a common-anode 7-segment bank showing mm:ss.
// It snapshots the BCD time once per frame, blanks between digits, and supports blinking.
module display_scanner #(
    parameter int REFRESH_DIV  = 4,
    parameter int BLINK_FRAMES = 64,
    parameter bit LZ_BLANK     = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_q,
    input  logic        i_blink,
    output logic [3:0]  o_an,
    output logic [6:0]  o_seg,
    output logic        o_dp,
    output logic        o_frame
);

    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam int BCNT_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [BCNT_W-1:0] BLINK_TERM = BCNT_W'(BLINK_FRAMES);

    logic [SLOT_W-1:0] r_slot_cnt;
    logic [1:0]        r_idx;
    logic [15:0]       r_snap;
    logic [BCNT_W-1:0] r_blink_cnt;
    logic              r_blink_phase;
    logic [3:0]        r_an;
    logic [6:0]        r_seg;
    logic              r_dp;
    logic              r_frame;

    logic              w_slot_wrap;
    logic              w_snap_now;
    logic              w_dark;
    logic              w_lz;
    logic [3:0]        w_nibble;
    logic [6:0]        w_seg_dec;
    logic [3:0]        w_an_next;
    logic [6:0]        w_seg_next;
    logic              w_dp_next;

    function automatic logic [6:0] decodeDigit(input logic [3:0] value);
        case (value)
            4'd0:    decodeDigit = 7'b1000000;
            4'd1:    decodeDigit = 7'b1111001;
            4'd2:    decodeDigit = 7'b0100100;
            4'd3:    decodeDigit = 7'b0110000;
            4'd4:    decodeDigit = 7'b0011001;
            4'd5:    decodeDigit = 7'b0010010;
            4'd6:    decodeDigit = 7'b0000010;
            4'd7:    decodeDigit = 7'b1111000;
            4'd8:    decodeDigit = 7'b0000000;
            4'd9:    decodeDigit = 7'b0010000;
            default: decodeDigit = 7'b0111111;
        endcase
    endfunction

    assign w_slot_wrap = (r_slot_cnt == SLOT_LAST);
    assign w_snap_now  = (r_slot_cnt == '0) && (r_idx == 2'd0);
    // Dark phase only counts while blinking is requested, so dropping BLINK shows digits at once.
    assign w_dark      = r_blink_phase & i_blink;
    assign w_lz        = LZ_BLANK && (r_snap[15:12] == 4'd0) && (r_idx == 2'd3);

    always_comb begin
        case (r_idx)
            2'd0:    w_nibble = r_snap[3:0];
            2'd1:    w_nibble = r_snap[7:4];
            2'd2:    w_nibble = r_snap[11:8];
            default: w_nibble = r_snap[15:12];
        endcase
    end

    assign w_seg_dec = decodeDigit(w_nibble);

    always_comb begin
        w_an_next  = 4'b1111;
        w_seg_next = 7'b1111111;
        w_dp_next  = 1'b1;
        if ((r_slot_cnt != '0) && !w_dark && !w_lz) begin
            w_an_next  = ~(4'b0001 << r_idx);
            w_seg_next = w_seg_dec;
            w_dp_next  = (r_idx != 2'd2);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_slot_cnt    <= '0;
            r_idx         <= 2'd0;
            r_snap        <= 16'h0000;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_an          <= 4'b1111;
            r_seg         <= 7'b1111111;
            r_dp          <= 1'b1;
            r_frame       <= 1'b0;
        end else begin
            if (w_slot_wrap) begin
                r_slot_cnt <= '0;
                r_idx      <= r_idx + 2'd1;
            end else begin
                r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
            end

            r_frame <= w_snap_now;
            if (w_snap_now) begin
                r_snap <= i_q;
            end

            // blink_cnt holds frames already shown in the current phase, so each phase lasts BLINK_FRAMES.
            if (!i_blink) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= 1'b0;
            end else if (w_snap_now) begin
                if (r_blink_cnt == BLINK_TERM) begin
                    r_blink_cnt   <= BCNT_W'(1);
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BCNT_W'(1);
                end
            end

            r_an  <= w_an_next;
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
        end
    end

    assign o_an    = r_an;
    assign o_seg   = r_seg;
    assign o_dp    = r_dp;
    assign o_frame = r_frame;

endmodule
